// File: rtl/fetch_hazard_ctrl.sv
// Fetch/IF-ID/ID-EX sequencing: load-use stalls, taken-branch flushes, debug halt/step FSM, saturating counters.
// Control outputs are same-cycle combinational; halted and counters are registered.
module fetch_hazard_ctrl #(
  parameter int CNT_WIDTH  = 16,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead_EX,
  input  logic [REG_ADDR_W-1:0] rd_EX,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  branch_taken_EX,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  resume_req,
  input  logic                  cnt_clr,
  output logic                  PC_write,
  output logic                  PCSrc,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  stall_count,
  output logic [CNT_WIDTH-1:0]  flush_count
);

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic                 halted_q;
  logic [CNT_WIDTH-1:0] stall_q, stall_d, flush_q, flush_d;
  logic                 hz, stall_inc, flush_inc;

  assign hz = MemRead_EX && (rd_EX != '0) && ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

  always_comb begin
    state_d     = state_q;
    PC_write    = 1'b1;
    PCSrc       = 1'b0;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (branch_taken_EX) begin
      PCSrc       = 1'b1;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
      flush_inc   = 1'b1;
    end else if (hz && (state_q != S_HALTED)) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      stall_inc   = 1'b1;
    end else if (state_q == S_HALTED) begin
      // Freeze fetch and keep injecting bubbles so older instructions drain.
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
    end

    unique case (state_q)
      S_RUN:    if (halt_req) state_d = S_HALTED;
      S_HALTED: begin
        if (resume_req)    state_d = S_RUN;
        else if (step_req) state_d = S_STEP;
      end
      S_STEP:   if (PC_write) state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase

    // While reset is held, keep the pipeline frozen and bubbled.
    if (!reset) begin
      PC_write    = 1'b0;
      PCSrc       = 1'b0;
      IF_ID_write = 1'b0;
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (cnt_clr) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (stall_inc && (stall_q != CNT_MAX)) stall_d = stall_q + 1'b1;
      if (flush_inc && (flush_q != CNT_MAX)) flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALTED);
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign halted      = halted_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: doc/fetch_hazard_ctrl.md
# fetch_hazard_ctrl

Pipeline controller that sequences the fetch stage and the IF/ID and ID/EX boundaries of the 5-stage core. It detects load-use hazards, applies taken-branch redirects and flushes, and runs a debug halt/single-step state machine. It also keeps saturating stall and flush counters. It drives the fetch stage's `PC_write` and `PCSrc` inputs, plus the IF/ID write-enable and flush controls.

## Interface
- `CNT_WIDTH`, 16, width of each performance counter.
- `REG_ADDR_W`, 5, register-index width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `MemRead_EX`  in  1  the instruction in EX is a load.
- `rd_EX`  in  REG_ADDR_W  destination register of the instruction in EX.
- `rs1_ID`, `rs2_ID`  in  REG_ADDR_W  source registers of the instruction in ID.
- `branch_taken_EX`  in  1  the branch/jump resolved in EX is taken.
- `halt_req`, `step_req`, `resume_req`  in  1  debug requests, single-cycle pulses.
- `cnt_clr`  in  1  synchronous clear of both counters.
- `PC_write`  out  1  PC register enable.
- `PCSrc`  out  1  selects `PC_Branch` into the PC.
- `IF_ID_write`  out  1  IF/ID register enable.
- `IF_ID_flush`  out  1  zero the IF/ID instruction (NOP) at the next edge.
- `ID_EX_flush`  out  1  zero the ID/EX control bits (bubble) at the next edge.
- `halted`  out  1  the FSM is in HALTED.
- `stall_count`  out  CNT_WIDTH  load-use bubble cycles, saturating.
- `flush_count`  out  CNT_WIDTH  taken-branch flushes, saturating.

## Operation
- Hazard term: `hz = MemRead_EX & (rd_EX != 0) & (rd_EX == rs1_ID | rd_EX == rs2_ID)`.
- FSM states are RUN, HALTED and STEP.
- Outputs are combinational from the current state and the inputs. `halted` and both counters are registered.
- Priority within a cycle: branch, then hazard, then state behaviour.
- **Branch** (`branch_taken_EX`=1), honoured in every state:
  - `PCSrc`=1, `PC_write`=1, `IF_ID_write`=1, `IF_ID_flush`=1, `ID_EX_flush`=1.
  - `flush_count` increments.
  - `hz` is ignored, and `stall_count` does not increment.
- **Hazard** (no branch, `hz`=1) in RUN or STEP:
  - `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1, `IF_ID_flush`=0.
  - `stall_count` increments.
- **RUN**, no branch and no hazard: `PC_write`=1, `IF_ID_write`=1, all flushes 0, `PCSrc`=0.
- **HALTED**, no branch:
  - `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1, so bubbles drain EX/MEM/WB.
  - `hz` does not count as a stall.
- **STEP**: behaves as RUN for exactly one advancing cycle. An advancing cycle is any cycle with `PC_write`=1, either a plain advance or a branch.
- Transitions:
  - RUN to HALTED on `halt_req`.
  - HALTED to RUN on `resume_req`.
  - HALTED to STEP on `step_req`.
  - STEP to HALTED after an advancing cycle. STEP stays in STEP while `hz` stalls it.
  - `halt_req` in HALTED or STEP is ignored.
- Simultaneous requests:
  - `resume_req` beats `step_req`.
  - `halt_req` together with a branch: the branch is honoured this cycle and the state moves to HALTED.
  - `resume_req`/`step_req` in RUN are ignored.
- Counters:
  - Add 1 per qualifying cycle and saturate at 2^CNT_WIDTH−1.
  - `cnt_clr` zeroes both counters and wins over an increment in the same cycle.
- Reset value of every output:
  - State RUN, `halted`=0, both counters 0.
  - While `reset`=0: `PC_write`=0, `IF_ID_write`=0, `IF_ID_flush`=1, `ID_EX_flush`=1, `PCSrc`=0.

## Timing
- Hazard/branch response is zero-latency (same-cycle combinational). It takes effect at the next rising edge in PC and the pipeline registers.
- A load-use stall lasts exactly 1 cycle, because the load moves to MEM and `hz` drops.
- `halt_req` at edge N: state is HALTED after N. `PC_write`=0 from cycle N+1, and `halted`=1 in cycle N+1.
- `step_req` with no hazard: exactly one new PC value is latched, then HALTED, so `halted` drops for exactly 1 cycle.
- Reset may be asserted mid-operation, including mid-STEP. The FSM returns to RUN immediately (asynchronously) with counters 0. Release is synchronous to `clk`.

## Test plan
- Reset, then `rd_EX`=5, `rs1_ID`=5, `MemRead_EX`=1 for one cycle:
  - That cycle: `PC_write`=0, `IF_ID_write`=0, `ID_EX_flush`=1.
  - Next cycle: `PC_write`=1, `stall_count`=1.
- `MemRead_EX`=1 with `rd_EX`=0 and `rs1_ID`=0: no stall, `stall_count` stays 0.
- `branch_taken_EX`=1 with `hz`=1 in the same cycle:
  - `PCSrc`=1, `PC_write`=1, both flushes 1.
  - `flush_count`=1, `stall_count` unchanged.
- `halt_req`, then 3 idle cycles, then `step_req`, then `resume_req`:
  - PC frozen while halted.
  - Exactly +4 PC after the step.
  - `halted` sequence 1,1,1,0,1, then 0 after resume.
- `step_req` while HALTED with `hz`=1 on the first STEP cycle: STEP holds 2 cycles, PC advances once, then `halted`=1.
- Counter saturation and clear:
  - With CNT_WIDTH=4, apply 20 branch cycles: `flush_count`=15.
  - `cnt_clr` with a branch in the same cycle gives 0.
  - Assert reset mid-STEP: `halted`=0 and counters 0 immediately.
